// File: rtl/if_stage.sv
// if_stage: MIPS instruction-fetch stage owning the PC and the IF/ID register,
// with stall, flush, jump/branch redirect and halt/resume control.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_adr,
    input  logic [31:0] imem_data,
    input  logic        stall,
    input  logic        flush,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jmp,
    input  logic [31:0] jmp_target,
    input  logic        halt_req,
    input  logic        resume,
    output logic [31:0] if_id_inst,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic [31:0] pc,
    output logic        halted,
    output logic [31:0] fetch_count,
    output logic        misalign
);
    typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d, inst_q, inst_d, pc4_q, pc4_d, cnt_q, cnt_d;
    logic        valid_q, valid_d, mis_q, mis_d;
    logic        run, redir, bubble, load;
    logic [31:0] tgt, seq;

    assign run    = state_q == RUN;
    assign redir  = run & (jmp | br_taken);
    assign tgt    = jmp ? jmp_target : br_target;
    assign seq    = pc_q + 32'd4;
    // The word fetched alongside a redirect or flush is on the wrong path.
    assign bubble = ~run | redir | flush;
    assign load   = ~bubble & ~stall;

    always_comb begin
        pc_d    = redir ? {tgt[31:2], 2'b00} : (run & ~stall) ? seq : pc_q;
        inst_d  = bubble ? NOP_INST : load ? imem_data : inst_q;
        valid_d = ~bubble & (load | valid_q);
        pc4_d   = load ? seq : pc4_q;
        cnt_d   = cnt_q + {31'b0, load};
        mis_d   = redir & (tgt[1:0] != 2'b00);
        state_d = (state_q == BOOT) ? RUN
                : run ? (halt_req ? HALT : RUN)
                : (resume ? RUN : HALT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            inst_q  <= NOP_INST;
            pc4_q   <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            mis_q   <= mis_d;
        end
    end

    assign imem_adr    = pc_q;
    assign pc          = pc_q;
    assign if_id_inst  = inst_q;
    assign if_id_pc4   = pc4_q;
    assign if_id_valid = valid_q;
    assign fetch_count = cnt_q;
    assign misalign    = mis_q;
    assign halted      = state_q == HALT;
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed walk through the fetch-stage scenarios plus randomized
// traffic, all checked against a behavioural model of the fetch stage.
module tb_if_stage;
    logic        clk = 0;
    logic        rst = 1;
    logic [31:0] imem_adr, imem_data;
    logic        stall = 0, flush = 0, br_taken = 0, jmp = 0, halt_req = 0, resume = 0;
    logic [31:0] br_target = 0, jmp_target = 0;
    logic [31:0] if_id_inst, if_id_pc4, pc, fetch_count;
    logic        if_id_valid, halted, misalign;

    logic [31:0] mem [256];
    int checks = 0, errors = 0;

    always #5 clk = ~clk;
    assign imem_data = mem[imem_adr[9:2]];

    if_stage dut (
        .clk(clk), .rst(rst), .imem_adr(imem_adr), .imem_data(imem_data),
        .stall(stall), .flush(flush), .br_taken(br_taken), .br_target(br_target),
        .jmp(jmp), .jmp_target(jmp_target), .halt_req(halt_req), .resume(resume),
        .if_id_inst(if_id_inst), .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid),
        .pc(pc), .halted(halted), .fetch_count(fetch_count), .misalign(misalign)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: mode 0 = boot, 1 = running, 2 = halted.
    int          m_mode;
    bit          m_known = 0;
    logic [31:0] m_pc, m_inst, m_pc4, m_cnt;
    bit          m_valid, m_mis;

    always @(posedge clk) begin
        if (rst) begin
            m_mode = 0; m_pc = 0; m_inst = 0; m_pc4 = 0; m_cnt = 0;
            m_valid = 0; m_mis = 0; m_known = 1;
        end else if (m_known) begin
            m_mis = 0;
            if (m_mode != 1) begin
                m_inst = 0; m_valid = 0;
                if (m_mode == 0 || resume) m_mode = 1;
            end else begin
                logic [31:0] old_pc, t;
                old_pc = m_pc;
                t = jmp ? jmp_target : br_target;
                if (jmp || br_taken) begin
                    m_pc  = t - (t % 4);
                    m_mis = (t % 4) != 0;
                end else if (!stall) m_pc = old_pc + 4;
                if (jmp || br_taken || flush) begin
                    m_inst = 0; m_valid = 0;
                end else if (!stall) begin
                    m_inst  = mem[(old_pc / 4) % 256];
                    m_pc4   = old_pc + 4;
                    m_valid = 1;
                    m_cnt   = m_cnt + 1;
                end
                if (halt_req) m_mode = 2;
            end
        end
    end

    always @(negedge clk) begin
        if (m_known) begin
            chk("pc", pc, m_pc);
            chk("imem_adr", imem_adr, m_pc);
            chk("inst", if_id_inst, m_inst);
            chk("valid", {31'b0, if_id_valid}, {31'b0, m_valid});
            if (m_valid) chk("pc4", if_id_pc4, m_pc4);
            chk("count", fetch_count, m_cnt);
            chk("misalign", {31'b0, misalign}, {31'b0, m_mis});
            chk("halted", {31'b0, halted}, {31'b0, m_mode == 2});
        end
    end

    task automatic step;
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic go(input logic s, f, b, input logic [31:0] bt,
                      input logic j, input logic [31:0] jt, input logic h, r);
        stall = s; flush = f; br_taken = b; br_target = bt;
        jmp = j; jmp_target = jt; halt_req = h; resume = r;
        step();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        rst = 1;
        go(0, 0, 0, 0, 0, 0, 0, 0);
        rst = 0;
        chk("lit reset pc", pc, 32'h0);
        chk("lit reset valid", {31'b0, if_id_valid}, 32'h0);
        chk("lit reset count", fetch_count, 32'h0);
        go(0, 0, 0, 0, 0, 0, 0, 0);
        chk("lit boot pc", pc, 32'h0);
        chk("lit boot valid", {31'b0, if_id_valid}, 32'h0);
        go(0, 0, 0, 0, 0, 0, 0, 0);
        chk("lit W0", if_id_inst, mem[0]);
        chk("lit W0 pc4", if_id_pc4, 32'h4);
        chk("lit W0 valid", {31'b0, if_id_valid}, 32'h1);
        chk("lit pc4", pc, 32'h4);
        go(0, 0, 0, 0, 0, 0, 0, 0);
        go(1, 0, 0, 0, 0, 0, 0, 0);
        go(1, 0, 0, 0, 0, 0, 0, 0);
        chk("lit stall pc", pc, 32'h8);
        chk("lit stall inst", if_id_inst, mem[1]);
        chk("lit stall pc4", if_id_pc4, 32'h8);
        chk("lit stall count", fetch_count, 32'h2);
        go(0, 0, 0, 0, 0, 0, 0, 0);
        chk("lit W2", if_id_inst, mem[2]);
        chk("lit count3", fetch_count, 32'h3);
        go(1, 0, 1, 32'h40, 0, 0, 0, 0);
        chk("lit br pc", pc, 32'h40);
        chk("lit br valid", {31'b0, if_id_valid}, 32'h0);
        go(0, 0, 0, 0, 0, 0, 0, 0);
        chk("lit br inst", if_id_inst, mem[16]);
        chk("lit br pc4", if_id_pc4, 32'h44);
        go(0, 0, 1, 32'h200, 1, 32'h100, 0, 0);
        chk("lit jmp prio", pc, 32'h100);
        go(0, 0, 0, 0, 1, 32'h103, 0, 0);
        chk("lit mis pc", pc, 32'h100);
        chk("lit mis", {31'b0, misalign}, 32'h1);
        go(0, 0, 0, 0, 0, 0, 0, 0);
        chk("lit mis clr", {31'b0, misalign}, 32'h0);
        go(0, 0, 0, 0, 1, 32'h10, 0, 0);
        go(0, 0, 0, 0, 0, 0, 1, 0);
        chk("lit halt", {31'b0, halted}, 32'h1);
        chk("lit halt pc", pc, 32'h14);
        go(0, 0, 1, 32'h80, 0, 0, 0, 0);
        chk("lit halt frozen", pc, 32'h14);
        chk("lit halt valid", {31'b0, if_id_valid}, 32'h0);
        go(0, 0, 0, 0, 0, 0, 0, 1);
        chk("lit resumed", {31'b0, halted}, 32'h0);
        go(0, 0, 0, 0, 0, 0, 0, 0);
        chk("lit resume inst", if_id_inst, mem[5]);
        chk("lit resume pc", pc, 32'h18);
        go(0, 0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0);
        chk("lit top pc", pc, 32'hFFFF_FFFC);
        go(0, 0, 0, 0, 0, 0, 0, 0);
        chk("lit wrap pc", pc, 32'h0);
        chk("lit wrap pc4", if_id_pc4, 32'h0);
        rst = 1;
        go(0, 0, 0, 0, 1, 32'h203, 0, 0);
        rst = 0;
        chk("lit rst pc", pc, 32'h0);
        chk("lit rst count", fetch_count, 32'h0);
        chk("lit rst mis", {31'b0, misalign}, 32'h0);
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom % 150) == 0;
            go(($urandom % 4) == 0, ($urandom % 10) == 0, ($urandom % 8) == 0, $urandom,
               ($urandom % 10) == 0, $urandom, ($urandom % 25) == 0, ($urandom % 3) == 0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
